// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the approximate sequential multiplier.
// Consumed by approx_mul_seq and approx_mul_err_mon.
package approx_mul_pkg;

    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Keep-mask over a 2*width product: columns below cols are dropped.
    function automatic logic [63:0] trunc_mask(input int unsigned width,
                                               input int unsigned cols);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            m[i] = (i >= cols) && (i < 2 * width);
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_mul_err_mon.sv
// Error monitor: exact shadow accumulator, error-vs-approx compare, running max
// and saturating violation counter. Only built when ERROR_MONITOR_EN is defined.
module approx_mul_err_mon
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ET    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [2*WIDTH-1:0]   step_val,
    input  logic                 deliver,
    input  logic [2*WIDTH-1:0]   approx,
    input  logic                 err_clr,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]        exact_q, exact_d;
    logic [PW-1:0]        max_q, max_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        err;
    logic                 violation;

    // Truncation only ever removes value, so this never underflows.
    assign err       = exact_q - approx;
    assign violation = 64'(err) > 64'(ET);

    always_comb begin
        exact_d = exact_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        if (start) begin
            exact_d = '0;
        end else if (step) begin
            exact_d = exact_q + step_val;
        end
        if (err_clr) begin
            max_d = '0;
            cnt_d = '0;
        end else if (deliver) begin
            if (err > max_q) begin
                max_d = err;
            end
            if (violation && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            exact_q <= exact_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_max = max_q;
    assign err_cnt = cnt_q;

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-and-add approximate multiplier with per-partial-product column
// truncation behind valid/ready. Define ERROR_MONITOR_EN to build the error monitor.
module approx_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned TRUNC_COLS = 2,
    parameter int unsigned ET         = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    input  logic                 err_clr,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] Mask = PW'(trunc_mask(WIDTH, TRUNC_COLS));

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]    partial;
    logic             last_step;
    logic             accept;
    logic             deliver;

    assign partial   = {{WIDTH{1'b0}}, a_q} << cnt_q;
    assign last_step = (cnt_q == CntW'(WIDTH - 1));

    // Gating with rst keeps both handshakes dead while reset is held.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone) && !rst;
    assign out_p     = (state_q == StDone) ? acc_q : '0;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + (partial & Mask);
                end
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (deliver) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ERROR_MONITOR_EN
    approx_mul_err_mon #(
        .WIDTH(WIDTH),
        .ET   (ET)
    ) u_err_mon (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .step    ((state_q == StBusy) && b_q[cnt_q]),
        .step_val(partial),
        .deliver (deliver),
        .approx  (acc_q),
        .err_clr (err_clr),
        .err_max (err_max),
        .err_cnt (err_cnt)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_max        = '0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_approx_mul_seq.sv
// Randomised self-checking bench for approx_mul_seq against an arithmetic model
// of truncated shift-and-add, including the optional error monitor.
module tb_approx_mul_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned T  = 2;
    localparam int unsigned ET = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           err_clr;
    logic [2*W-1:0] err_max;
    logic [15:0]    err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_max = 0;
    int exp_cnt = 0;

    approx_mul_seq #(
        .WIDTH     (W),
        .TRUNC_COLS(T),
        .ET        (ET)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .err_clr  (err_clr),
        .err_max  (err_max),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sum of partial products, each with its low T columns floored away.
    function automatic int ref_approx(input int a, input int b);
        int sum = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (((b >> i) & 1) == 1) sum += (((a * (2 ** i)) / (2 ** T)) * (2 ** T));
        end
        return sum;
    endfunction

    task automatic check_mon();
`ifdef ERROR_MONITOR_EN
        check("err_max", err_max, exp_max);
        check("err_cnt", err_cnt, exp_cnt);
`else
        check("err_max_tied", err_max, 0);
        check("err_cnt_tied", err_cnt, 0);
`endif
    endtask

    task automatic do_mul(input int a, input int b, input int hold, input bit early,
                          input bit clr_hs);
        int lat;
        int exp_p;
        int e;
        exp_p = ref_approx(a, b);
        e     = a * b - exp_p;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_a      = W'(a);
        in_b      = W'(b);
        out_ready = early;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        check("out_p", out_p, exp_p);
        check("in_ready_done", in_ready, 0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_p", out_p, exp_p);
                check("hold_in_ready", in_ready, 0);
            end
        end
        err_clr   = clr_hs;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        err_clr   = 1'b0;
        if (clr_hs) begin
            exp_max = 0;
            exp_cnt = 0;
        end else begin
            if (e > exp_max) exp_max = e;
            if (e > int'(ET) && exp_cnt < 65535) exp_cnt++;
        end
        check("out_valid_low", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check_mon();
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_err_max", err_max, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        do_mul(3, 3, 0, 1'b0, 1'b0);
        do_mul(15, 15, 0, 1'b1, 1'b0);
        do_mul(2, 1, 10, 1'b0, 1'b0);

        // Reset two cycles into a multiply must drop the result.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 4'd7;
        in_b     = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst     = 1'b0;
        out_ready = 1'b1;
        exp_max = 0;
        exp_cnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        out_ready = 1'b0;
        check("midrst_no_valid", seen, 0);
        check_mon();

        do_mul(1, 1, 0, 1'b0, 1'b0);
        do_mul(3, 3, 1, 1'b0, 1'b0);
        do_mul(7, 6, 0, 1'b1, 1'b0);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_max = 0;
        exp_cnt = 0;
        check_mon();

        do_mul(13, 11, 2, 1'b0, 1'b0);
        do_mul(3, 3, 2, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            do_mul(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
